flag_ctx_stack: RTL and testbench
=================================

Name: flag_ctx_stack

Overview:
- Parametrised successor to the ALU status-flag register.
- Holds NFLAGS status flags with per-bit masked writes from the datapath.
- Adds a LIFO shadow stack so interrupt entry saves the live flags and return-from-interrupt restores them, which allows nested interrupts up to DEPTH levels.
- Sits between the ALU flag outputs, the interrupt controller (push/pop strobes) and the branch unit (flag consumers).

Parameters:
- NFLAGS, 4, number of flag bits (bit 0 = C, 1 = Z, 2 = N, 3 = V; bits ≥4 are user-defined).
- DEPTH, 4, number of saved contexts in the shadow stack (≥1).
- INT_MASK, '1, per-bit mask of flags overwritten by int_flags_i on push; unmasked bits keep their live value.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- clock_en  in  1  synchronous enable; when 0 all state holds. No clock gating.
- we  in  1  normal flag write strobe.
- wmask_i  in  NFLAGS  per-bit write mask for we.
- flags_i  in  NFLAGS  flag values from ALU.
- push_i  in  1  interrupt entry: save context, load interrupt flags.
- pop_i  in  1  interrupt return: restore saved context.
- int_flags_i  in  NFLAGS  flag values loaded on push.
- err_clr_i  in  1  clears sticky error bits.
- flags_o  out  NFLAGS  live flags (registered).
- level_o  out  $clog2(DEPTH+1)  number of saved contexts.
- full_o  out  1  level_o == DEPTH.
- empty_o  out  1  level_o == 0.
- ovf_o  out  1  sticky: push attempted while full.
- unf_o  out  1  sticky: pop attempted while empty.

Behaviour:
- Reset (rst_n low, asynchronous): flags_o=0, level_o=0, empty_o=1, full_o=0, ovf_o=0, unf_o=0. Stack contents are don't-care.
- Reset released mid-operation: the first active edge with clock_en=1 acts normally. No pending push or pop survives reset.
- All updates occur on the rising clk edge with clock_en=1. With clock_en=0 nothing changes, including err_clr_i handling.
- Flags hold when no write occurs. The old clear-on-idle behaviour is removed.
- Priority per cycle, evaluated with clock_en=1:
  1. push_i & pop_i (return immediately followed by re-entry): stack and level unchanged. flags_o <= (flags_o & ~INT_MASK) | (int_flags_i & INT_MASK). No error is raised, even when empty or full.
  2. push_i only, not full: stack[level] <= flags_o, level+1, flags_o <= masked int_flags_i as in case 1.
  3. push_i only, full: stack, level and flags unchanged; ovf_o <= 1.
  4. pop_i only, not empty: flags_o <= stack[level-1], level-1.
  5. pop_i only, empty: flags and level unchanged; unf_o <= 1.
  6. we only: flags_o <= (flags_o & ~wmask_i) | (flags_i & wmask_i).
- we is ignored in any cycle where push_i or pop_i is asserted. Push/pop take priority and the write is dropped.
- Latency: flags_o, level_o, full_o and empty_o reflect an operation one cycle after the edge that samples it. full_o and empty_o are decoded from registered level, so they carry no combinational path from inputs.
- Back-to-back push/pop on consecutive cycles are supported at full rate. No bubbles are required.
- err_clr_i clears ovf_o and unf_o. If a new error occurs in the same cycle, set wins over clear.
- Wrap-around: level never exceeds DEPTH or drops below 0. Stack indexing never wraps.

Decomposition:
- Package flag_pkg holds:
  - constants FLAG_C=0, FLAG_Z=1, FLAG_N=2, FLAG_V=3;
  - typedef flags_t (logic [NFLAGS-1:0] at default width);
  - localparam helper for the level width.
- One sub-module, flag_lifo: DEPTH x NFLAGS register array with push/pop/level/full/empty. It has no error logic; error stickies and priority live in the top.

Test Plan:
- Reset then we=1, wmask_i=4'b0011, flags_i=4'b1111 -> flags_o=4'b0011; next idle cycle -> flags_o stays 4'b0011 (hold, no clear).
- flags_o=4'b0101, push_i with int_flags_i=4'b0000 -> flags_o=0, level_o=1. Then pop_i -> flags_o=4'b0101, level_o=0, empty_o=1.
- DEPTH=4, five pushes with distinct live flags 1,2,3,4,5 -> level_o=4, full_o=1, ovf_o=1 after the 5th, flags_o=5 unchanged by the 5th push. Four pops restore 4,3,2,1 in order.
- Pop when empty -> unf_o=1, flags_o unchanged. err_clr_i together with another empty pop -> unf_o stays 1. err_clr_i alone -> unf_o=0.
- level_o=2, flags_o=4'b1000, push_i & pop_i & we same cycle, int_flags_i=4'b0110 -> flags_o=4'b0110, level_o=2, no error, we dropped.
- clock_en=0 with push_i=1 -> no change. Assert rst_n low asynchronously mid-sequence with level_o=3 -> all outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/flag_pkg.sv
// Shared constants, types and sizing helpers for the status-flag context stack.
package flag_pkg;

  localparam int NFLAGS_DEF = 4;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;

  typedef logic [NFLAGS_DEF-1:0] flags_t;

  // Level counts 0..DEPTH inclusive, so it needs one more code than the depth.
  function automatic int level_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/flag_lifo.sv
// Shadow stack of saved flag contexts: DEPTH x NFLAGS registers with push/pop and level tracking.
module flag_lifo
  import flag_pkg::*;
#(
  parameter int NFLAGS = NFLAGS_DEF,
  parameter int DEPTH  = 4,
  parameter int LW     = level_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [NFLAGS-1:0] din_i,
  output logic [NFLAGS-1:0] dout_o,
  output logic [LW-1:0]     level_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [NFLAGS-1:0] mem_q [DEPTH];
  logic [NFLAGS-1:0] mem_d [DEPTH];
  logic [LW-1:0]     level_q;
  logic [LW-1:0]     level_d;
  logic [LW-1:0]     top_s;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == LW'(0));
  assign level_o = level_q;
  assign top_s   = level_q - LW'(1);
  assign dout_o  = mem_q[top_s[AW-1:0]];

  // Next stack contents and level; full/empty guards keep the index in range.
  always_comb begin
    mem_d   = mem_q;
    level_d = level_q;
    if (push_i && !full_o) begin
      mem_d[level_q[AW-1:0]] = din_i;
      level_d                = level_q + LW'(1);
    end else if (pop_i && !empty_o) begin
      level_d = level_q - LW'(1);
    end else begin
      level_d = level_q;
    end
  end

  // Level register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= LW'(0);
    end else begin
      level_q <= level_d;
    end
  end

  // Saved contexts are meaningless after reset, so the array carries no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/flag_ctx_stack.sv
// Live status flags with masked datapath writes and a LIFO save/restore for nested interrupts.
module flag_ctx_stack
  import flag_pkg::*;
#(
  parameter int                NFLAGS   = NFLAGS_DEF,
  parameter int                DEPTH    = 4,
  parameter logic [NFLAGS-1:0] INT_MASK = '1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clock_en,
  input  logic                          we,
  input  logic [NFLAGS-1:0]             wmask_i,
  input  logic [NFLAGS-1:0]             flags_i,
  input  logic                          push_i,
  input  logic                          pop_i,
  input  logic [NFLAGS-1:0]             int_flags_i,
  input  logic                          err_clr_i,
  output logic [NFLAGS-1:0]             flags_o,
  output logic [level_width(DEPTH)-1:0] level_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic                          ovf_o,
  output logic                          unf_o
);

  localparam int LW = level_width(DEPTH);

  logic [NFLAGS-1:0] flags_q;
  logic [NFLAGS-1:0] flags_d;
  logic              ovf_q;
  logic              ovf_d;
  logic              unf_q;
  logic              unf_d;
  logic [NFLAGS-1:0] int_load_s;
  logic [NFLAGS-1:0] lifo_dout_s;
  logic              lifo_push_s;
  logic              lifo_pop_s;
  logic              lifo_full_s;
  logic              lifo_empty_s;

  assign int_load_s  = (flags_q & ~INT_MASK) | (int_flags_i & INT_MASK);
  assign lifo_push_s = clock_en & push_i & ~pop_i & ~lifo_full_s;
  assign lifo_pop_s  = clock_en & pop_i & ~push_i & ~lifo_empty_s;

  flag_lifo #(
    .NFLAGS (NFLAGS),
    .DEPTH  (DEPTH),
    .LW     (LW)
  ) u_lifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (lifo_push_s),
    .pop_i   (lifo_pop_s),
    .din_i   (flags_q),
    .dout_o  (lifo_dout_s),
    .level_o (level_o),
    .full_o  (lifo_full_s),
    .empty_o (lifo_empty_s)
  );

  // Per-cycle priority: simultaneous push/pop reloads interrupt flags in place,
  // then push, then pop, then the datapath write. Error set beats clear.
  always_comb begin
    flags_d = flags_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (clock_en) begin
      if (err_clr_i) begin
        ovf_d = 1'b0;
        unf_d = 1'b0;
      end else begin
        ovf_d = ovf_q;
        unf_d = unf_q;
      end
      if (push_i && pop_i) begin
        flags_d = int_load_s;
      end else if (push_i) begin
        if (!lifo_full_s) begin
          flags_d = int_load_s;
        end else begin
          ovf_d = 1'b1;
        end
      end else if (pop_i) begin
        if (!lifo_empty_s) begin
          flags_d = lifo_dout_s;
        end else begin
          unf_d = 1'b1;
        end
      end else if (we) begin
        flags_d = (flags_q & ~wmask_i) | (flags_i & wmask_i);
      end else begin
        flags_d = flags_q;
      end
    end else begin
      flags_d = flags_q;
    end
  end

  // Live flags and sticky error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= {NFLAGS{1'b0}};
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign flags_o = flags_q;
  assign ovf_o   = ovf_q;
  assign unf_o   = unf_q;
  assign full_o  = lifo_full_s;
  assign empty_o = lifo_empty_s;

endmodule

// File: tb/tb_flag_ctx_stack.sv
// Self-checking bench for flag_ctx_stack: directed scenarios plus randomized traffic against a queue model.
module tb_flag_ctx_stack;
  import flag_pkg::*;

  localparam int             NF    = 4;
  localparam int             DEPTH = 4;
  localparam int             LW    = level_width(DEPTH);
  localparam logic [NF-1:0]  IM    = '1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clock_en;
  logic          we;
  logic [NF-1:0] wmask_i;
  logic [NF-1:0] flags_i;
  logic          push_i;
  logic          pop_i;
  logic [NF-1:0] int_flags_i;
  logic          err_clr_i;
  logic [NF-1:0] flags_o;
  logic [LW-1:0] level_o;
  logic          full_o;
  logic          empty_o;
  logic          ovf_o;
  logic          unf_o;

  int n_chk  = 0;
  int n_fail = 0;
  bit started = 1'b0;

  flags_t m_flags;
  flags_t m_stk[$];
  bit     m_ovf;
  bit     m_unf;

  flag_ctx_stack #(.NFLAGS(NF), .DEPTH(DEPTH), .INT_MASK(IM)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clock_en    (clock_en),
    .we          (we),
    .wmask_i     (wmask_i),
    .flags_i     (flags_i),
    .push_i      (push_i),
    .pop_i       (pop_i),
    .int_flags_i (int_flags_i),
    .err_clr_i   (err_clr_i),
    .flags_o     (flags_o),
    .level_o     (level_o),
    .full_o      (full_o),
    .empty_o     (empty_o),
    .ovf_o       (ovf_o),
    .unf_o       (unf_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_flags = '0;
    m_stk.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // Architectural rules: stack as a queue, errors clear first so a new error wins.
  task automatic model_step();
    if (!clock_en) return;
    if (err_clr_i) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
    if (push_i && pop_i) begin
      m_flags = (m_flags & ~IM) | (int_flags_i & IM);
    end else if (push_i) begin
      if (m_stk.size() == DEPTH) m_ovf = 1'b1;
      else begin
        m_stk.push_back(m_flags);
        m_flags = (m_flags & ~IM) | (int_flags_i & IM);
      end
    end else if (pop_i) begin
      if (m_stk.size() == 0) m_unf = 1'b1;
      else m_flags = m_stk.pop_back();
    end else if (we) begin
      m_flags = (m_flags & ~wmask_i) | (flags_i & wmask_i);
    end
  endtask

  task automatic drive(input logic ce, input logic w, input logic [NF-1:0] wm, input logic [NF-1:0] fi,
                       input logic pu, input logic po, input logic [NF-1:0] ifl, input logic clr);
    clock_en    = ce;
    we          = w;
    wmask_i     = wm;
    flags_i     = fi;
    push_i      = pu;
    pop_i       = po;
    int_flags_i = ifl;
    err_clr_i   = clr;
    if (!rst_n) model_reset();
    else model_step();
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0);
  endtask

  // Every cycle: DUT outputs against the model state.
  always @(negedge clk) begin
    if (started) begin
      chk("flags_o", 32'(flags_o), 32'(m_flags));
      chk("level_o", 32'(level_o), 32'(m_stk.size()));
      chk("full_o",  32'(full_o),  32'(m_stk.size() == DEPTH));
      chk("empty_o", 32'(empty_o), 32'(m_stk.size() == 0));
      chk("ovf_o",   32'(ovf_o),   32'(m_ovf));
      chk("unf_o",   32'(unf_o),   32'(m_unf));
    end
  end

  initial begin
    rst_n = 1'b0;
    model_reset();
    idle();
    tick();
    tick();
    chk("rst_flags", 32'(flags_o), 32'h0);
    chk("rst_level", 32'(level_o), 32'h0);
    chk("rst_empty", 32'(empty_o), 32'h1);
    chk("rst_full",  32'(full_o),  32'h0);
    chk("rst_ovf",   32'(ovf_o),   32'h0);
    chk("rst_unf",   32'(unf_o),   32'h0);
    rst_n = 1'b1;
    started = 1'b1;

    drive(1'b1, 1'b1, 4'b0011, 4'b1111, 1'b0, 1'b0, 4'h0, 1'b0); tick();
    chk("masked_we", 32'(flags_o), 32'h3);
    idle(); tick();
    chk("hold_idle", 32'(flags_o), 32'h3);

    drive(1'b1, 1'b1, 4'hF, 4'b0101, 1'b0, 1'b0, 4'h0, 1'b0); tick();
    drive(1'b1, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 4'b0000, 1'b0); tick();
    chk("push_flags", 32'(flags_o), 32'h0);
    chk("push_level", 32'(level_o), 32'h1);
    drive(1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 4'h0, 1'b0); tick();
    chk("pop_flags", 32'(flags_o), 32'h5);
    chk("pop_level", 32'(level_o), 32'h0);
    chk("pop_empty", 32'(empty_o), 32'h1);

    drive(1'b1, 1'b1, 4'hF, 4'h1, 1'b0, 1'b0, 4'h0, 1'b0); tick();
    for (int k = 2; k <= 5; k++) begin
      drive(1'b1, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 4'(k), 1'b0); tick();
    end
    chk("fill_level", 32'(level_o), 32'h4);
    chk("fill_full",  32'(full_o),  32'h1);
    chk("fill_flags", 32'(flags_o), 32'h5);
    drive(1'b1, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 4'hF, 1'b0); tick();
    chk("ovf_set",   32'(ovf_o),   32'h1);
    chk("ovf_flags", 32'(flags_o), 32'h5);
    chk("ovf_level", 32'(level_o), 32'h4);
    for (int k = 4; k >= 1; k--) begin
      drive(1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 4'h0, 1'b0); tick();
      chk("lifo_order", 32'(flags_o), 32'(k));
    end
    chk("drain_empty", 32'(empty_o), 32'h1);

    drive(1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 4'h0, 1'b0); tick();
    chk("unf_set",   32'(unf_o),   32'h1);
    chk("unf_flags", 32'(flags_o), 32'h1);
    drive(1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 4'h0, 1'b1); tick();
    chk("set_beats_clr", 32'(unf_o), 32'h1);
    chk("ovf_cleared",   32'(ovf_o), 32'h0);
    drive(1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b1); tick();
    chk("unf_cleared", 32'(unf_o), 32'h0);

    drive(1'b1, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 4'h0, 1'b0); tick();
    drive(1'b1, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 4'h0, 1'b0); tick();
    drive(1'b1, 1'b1, 4'hF, 4'b1000, 1'b0, 1'b0, 4'h0, 1'b0); tick();
    drive(1'b1, 1'b1, 4'hF, 4'hF, 1'b1, 1'b1, 4'b0110, 1'b0); tick();
    chk("swap_flags", 32'(flags_o), 32'h6);
    chk("swap_level", 32'(level_o), 32'h2);
    chk("swap_noerr", 32'({ovf_o, unf_o}), 32'h0);

    drive(1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 4'hF, 1'b0); tick();
    chk("ce_off_flags", 32'(flags_o), 32'h6);
    chk("ce_off_level", 32'(level_o), 32'h2);
    drive(1'b1, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 4'h9, 1'b0); tick();
    chk("pre_rst_level", 32'(level_o), 32'h3);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_flags", 32'(flags_o), 32'h0);
    chk("async_level", 32'(level_o), 32'h0);
    chk("async_empty", 32'(empty_o), 32'h1);
    chk("async_full",  32'(full_o),  32'h0);
    drive(1'b1, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 4'h7, 1'b0); tick();
    rst_n = 1'b1;

    for (int i = 0; i < 1600; i++) begin
      logic pu;
      logic po;
      if ((i % 400) < 200) begin
        pu = ($urandom_range(0, 1) == 0);
        po = ($urandom_range(0, 3) == 0);
      end else begin
        pu = ($urandom_range(0, 3) == 0);
        po = ($urandom_range(0, 1) == 0);
      end
      rst_n = ($urandom_range(0, 249) != 0);
      drive(($urandom_range(0, 9) != 0), ($urandom_range(0, 1) == 0),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            pu, po, 4'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0));
      tick();
    end
    rst_n = 1'b1;
    idle(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
